// File: rtl/data_ram_arbiter.sv
// -----------------------------------------------------------------------------
// data_ram_arbiter
//
// Shares one single-port 32-bit data RAM (combinational read, synchronous
// write, no byte enables) between two requesters:
//   m0 : CPU MEM stage, priority port
//   m1 : DMA / debug port
// Sub-word stores are carried out as read-modify-write (ACCESS reads the old
// word, MERGE writes the merged word). m0 wins ties until it has been granted
// STARVE_LIMIT times in a row while m1 was waiting; then m1 is served once.
//
// Handshake: a requester raises mN_req with we/addr/sel/wdata stable and keeps
// them until it sees mN_ack=1 for one cycle. mN_rdata/mN_err are valid only
// while mN_ack=1 and are 0 otherwise. req still high after ack is a new request.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   m0_* / m1_*            requester ports (req, we, addr, sel, wdata in;
//                          ack, rdata, err out)
//   ram_ce, ram_we,        RAM control/address/write data (decoded from
//   ram_addr, ram_wdata    registered state only)
//   ram_rdata              RAM combinational read data
//   dbg_state              current FSM state (IDLE=0 ACCESS=1 MERGE=2 DONE=3)
// -----------------------------------------------------------------------------
module data_ram_arbiter #(
    parameter int unsigned RAM_AW       = 17,
    parameter int unsigned MEM_WORDS    = 131071,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [3:0]        m0_sel,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ack,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [3:0]        m1_sel,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,

    output logic              ram_ce,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,

    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned       SW        = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]     LIMIT     = SW'(STARVE_LIMIT);
    localparam logic [RAM_AW:0]   WORDS_LIM = (RAM_AW + 1)'(MEM_WORDS);

    state_t            state;
    logic              grant_q;     // 0 = m0, 1 = m1
    logic              we_q;
    logic [31:0]       addr_q;
    logic [3:0]        sel_q;
    logic [31:0]       wdata_q;
    logic [31:0]       old_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [SW-1:0]     starve_cnt;

    logic              m0_wins;
    logic [RAM_AW-1:0] word_idx;
    logic [31:0]       addr_hi;
    logic              out_of_range;
    logic              full_sel;
    logic              zero_sel;
    logic [31:0]       merged;

    // m0 keeps priority unless m1 has already been passed over STARVE_LIMIT times.
    assign m0_wins = m0_req && (!m1_req || (starve_cnt < LIMIT));

    assign word_idx     = addr_q[RAM_AW+1:2];
    assign addr_hi      = addr_q >> (RAM_AW + 2);
    assign out_of_range = ({1'b0, word_idx} >= WORDS_LIM) || (addr_hi != 32'd0);
    assign full_sel     = (sel_q == 4'b1111);
    assign zero_sel     = (sel_q == 4'b0000);

    always_comb begin
        merged = old_q;
        for (int i = 0; i < 4; i++) begin
            if (sel_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    // RAM interface decode. rst also masks ce/we so that a write that was
    // pending when reset arrived (MERGE) never reaches the RAM.
    always_comb begin
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = 32'd0;
        case (state)
            ACCESS: begin
                ram_addr = word_idx;
                if (!out_of_range) begin
                    if (!we_q) begin
                        ram_ce = 1'b1;
                    end else if (full_sel) begin
                        ram_ce    = 1'b1;
                        ram_we    = 1'b1;
                        ram_wdata = wdata_q;
                    end else if (!zero_sel) begin
                        ram_ce = 1'b1;      // RMW read phase
                    end
                end
            end
            MERGE: begin
                ram_ce    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = word_idx;
                ram_wdata = merged;
            end
            default: ;
        endcase
        if (rst) begin
            ram_ce = 1'b0;
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            sel_q      <= 4'd0;
            wdata_q    <= 32'd0;
            old_q      <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        if (m0_wins) begin
                            grant_q    <= 1'b0;
                            we_q       <= m0_we;
                            addr_q     <= m0_addr;
                            sel_q      <= m0_sel;
                            wdata_q    <= m0_wdata;
                            starve_cnt <= m1_req ? starve_cnt + 1'b1 : '0;
                        end else begin
                            grant_q    <= 1'b1;
                            we_q       <= m1_we;
                            addr_q     <= m1_addr;
                            sel_q      <= m1_sel;
                            wdata_q    <= m1_wdata;
                            starve_cnt <= '0;
                        end
                        rdata_q <= 32'd0;
                        err_q   <= 1'b0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (out_of_range) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'd0;
                        state   <= DONE;
                    end else if (!we_q) begin
                        rdata_q <= ram_rdata;
                        state   <= DONE;
                    end else if (full_sel || zero_sel) begin
                        state <= DONE;
                    end else begin
                        old_q <= ram_rdata;
                        state <= MERGE;
                    end
                end
                MERGE:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign m0_ack   = (state == DONE) && !grant_q;
    assign m0_rdata = m0_ack ? rdata_q : 32'd0;
    assign m0_err   = m0_ack && err_q;

    assign m1_ack   = (state == DONE) && grant_q;
    assign m1_rdata = m1_ack ? rdata_q : 32'd0;
    assign m1_err   = m1_ack && err_q;

    assign dbg_state = state;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_ram_arbiter
//
// Directed bench for data_ram_arbiter with a behavioural RAM (combinational
// read, write on clock edge). Drivers push the expected ack record
// {port, err, rdata} into exp_q; the monitor pops it on every ack.
// -----------------------------------------------------------------------------
module tb_data_ram_arbiter;

    localparam int RAM_AW = 17;

    logic              clk;
    logic              rst;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [31:0]       m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]        m0_sel, m1_sel;
    logic              m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0]       m0_rdata, m1_rdata;
    logic              ram_ce, ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;
    logic [1:0]        dbg_state;

    logic [31:0]       mem [0:(1<<RAM_AW)-1];

    logic [33:0]       exp_q[$];
    int                checks = 0;
    int                errors = 0;
    int                wr_cnt = 0;
    int                rd_cnt = 0;
    int                ack_cnt = 0;
    logic [RAM_AW-1:0] last_waddr = '0;
    logic [31:0]       last_wdata = 32'd0;

    data_ram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_sel    (m0_sel),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_sel    (m1_sel),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .m1_err    (m1_err),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_ce && ram_we) mem[ram_addr] <= ram_wdata;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: RAM activity counters and scoreboard pop on every ack.
    always @(negedge clk) begin
        logic [33:0] e;
        if (ram_ce && ram_we) begin
            wr_cnt++;
            last_waddr = ram_addr;
            last_wdata = ram_wdata;
        end
        if (ram_ce && !ram_we) rd_cnt++;
        if (m0_ack || m1_ack) begin
            ack_cnt++;
            check("dual_ack", {31'd0, m0_ack & m1_ack}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("ack_port", {31'd0, m1_ack}, {31'd0, e[33]});
                if (m1_ack) begin
                    check("ack_rdata", m1_rdata, e[31:0]);
                    check("ack_err", {31'd0, m1_err}, {31'd0, e[32]});
                    check("other_port_quiet", m0_rdata | {31'd0, m0_err}, 32'd0);
                end else begin
                    check("ack_rdata", m0_rdata, e[31:0]);
                    check("ack_err", {31'd0, m0_err}, {31'd0, e[32]});
                    check("other_port_quiet", m1_rdata | {31'd0, m1_err}, 32'd0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_port(input int p, input logic req, input logic we,
                            input logic [31:0] addr, input logic [3:0] sel,
                            input logic [31:0] wdata);
        if (p == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_sel = sel; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_sel = sel; m1_wdata = wdata;
        end
    endtask

    // One transaction from an idle DUT; latency counted from the IDLE sampling edge.
    task automatic txn(input string name, input int p, input logic we,
                       input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int exp_lat);
        int  k;
        logic got;
        exp_q.push_back({(p == 1), exp_err, exp_rdata});
        @(posedge clk); #1;
        set_port(p, 1'b1, we, addr, sel, wdata);
        k = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            got = (p == 0) ? m0_ack : m1_ack;
        end
        if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
        else      check({name, "_latency"}, 32'(k - 1), 32'(exp_lat));
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rd0, wr0, base, k;

        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[(1<<RAM_AW)-1] = 32'h0BADF00D;
        mem[(1<<RAM_AW)-2] = 32'd0;
        rst = 1'b1;
        set_port(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        set_port(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_ram_ctl", {30'd0, ram_ce, ram_we}, 32'd0);
        check("rst_ram_addr_data", 32'(ram_addr) | ram_wdata, 32'd0);
        check("rst_acks", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'd0);

        // no request: nothing happens
        rd0 = rd_cnt; wr0 = wr_cnt;
        repeat (8) @(negedge clk);
        check("idle_no_ram", 32'(rd_cnt - rd0 + wr_cnt - wr0), 32'd0);
        check("idle_state", 32'(dbg_state), 32'd0);

        // full word write then read
        rd0 = rd_cnt; wr0 = wr_cnt;
        txn("word_wr", 0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'd0, 1'b0, 2);
        check("word_wr_count", 32'(wr_cnt - wr0), 32'd1);
        check("word_wr_addr", 32'(last_waddr), 32'd4);
        check("word_wr_data", last_wdata, 32'hDEADBEEF);
        txn("word_rd", 0, 1'b0, 32'h10, 4'b1111, 32'd0, 32'hDEADBEEF, 1'b0, 2);

        // partial write (RMW) from m1
        mem[4] = 32'h11223344;
        rd0 = rd_cnt; wr0 = wr_cnt;
        txn("rmw_wr", 1, 1'b1, 32'h10, 4'b0101, 32'hAABBCCDD, 32'd0, 1'b0, 3);
        check("rmw_rd_count", 32'(rd_cnt - rd0), 32'd1);
        check("rmw_wr_count", 32'(wr_cnt - wr0), 32'd1);
        check("rmw_wr_addr", 32'(last_waddr), 32'd4);
        check("rmw_wr_data", last_wdata, 32'h11BB33DD);
        txn("rmw_rd", 1, 1'b0, 32'h10, 4'b1111, 32'd0, 32'h11BB33DD, 1'b0, 2);

        // out of range: last index, and a bit above the RAM window
        rd0 = rd_cnt; wr0 = wr_cnt;
        txn("oor_idx", 1, 1'b0, 32'h0007FFFC, 4'b1111, 32'd0, 32'd0, 1'b1, 2);
        txn("oor_hi", 0, 1'b1, 32'h00080010, 4'b1111, 32'h01020304, 32'd0, 1'b1, 2);
        check("oor_no_ram", 32'(rd_cnt - rd0 + wr_cnt - wr0), 32'd0);
        check("oor_hi_alias_untouched", mem[4], 32'h11BB33DD);

        // highest in-range word
        txn("edge_wr", 0, 1'b1, 32'h0007FFF8, 4'b1111, 32'h12345678, 32'd0, 1'b0, 2);
        txn("edge_rd", 1, 1'b0, 32'h0007FFF8, 4'b0000, 32'd0, 32'h12345678, 1'b0, 2);

        // zero-select write: no RAM access
        mem[8] = 32'hCAFEF00D;
        rd0 = rd_cnt; wr0 = wr_cnt;
        txn("zero_sel", 0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 32'd0, 1'b0, 2);
        check("zero_sel_no_ram", 32'(rd_cnt - rd0 + wr_cnt - wr0), 32'd0);
        check("zero_sel_mem", mem[8], 32'hCAFEF00D);

        // starvation: both held high, grants m0 x4 then m1, twice
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 4; j++) exp_q.push_back({1'b0, 1'b0, 32'h11BB33DD});
            exp_q.push_back({1'b1, 1'b0, 32'hCAFEF00D});
        end
        base = ack_cnt;
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, 32'h10, 4'b1111, 32'd0);
        set_port(1, 1'b1, 1'b0, 32'h20, 4'b1111, 32'd0);
        k = 0;
        while (ack_cnt < base + 10 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        check("starve_acks", 32'(ack_cnt - base), 32'd10);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        set_port(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);

        // reset during MERGE abandons the RMW write
        repeat (2) @(posedge clk);
        wr0 = wr_cnt;
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b1, 32'h10, 4'b0011, 32'h55667788);
        @(posedge clk);
        @(posedge clk); #1;
        check("rmw_in_merge", 32'(dbg_state), 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_port(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        @(negedge clk);
        check("rmwrst_no_write", 32'(wr_cnt - wr0), 32'd0);
        check("rmwrst_state", 32'(dbg_state), 32'd0);
        check("rmwrst_outputs", {28'd0, m0_ack, m1_ack, ram_ce, ram_we} | m0_rdata | m1_rdata, 32'd0);
        check("rmwrst_mem", mem[4], 32'h11BB33DD);
        txn("post_rst_rd", 0, 1'b0, 32'h10, 4'b1111, 32'd0, 32'h11BB33DD, 1'b0, 2);

        repeat (4) @(posedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
